// File: rtl/fifo_pkg.sv
// Shared FIFO definitions for the write-pointer/full and read-pointer/empty blocks:
// default depth, address-width helper and Gray conversion functions.
package fifo_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int GRAY_MAX_W    = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic int ptr_addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Callers zero-extend narrower pointers in and truncate the result back.
    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Bundle of the write-side producer signals and status returned by fifo_wptr_full.
// Handshake: a write is taken on a WCLK rising edge where winc=1 and wclk_en=1 (i.e. wfull=0).
interface fifo_wptr_full_if
    import fifo_pkg::*;
#(
    parameter int AW = ptr_addr_width(DEFAULT_DEPTH)
);

    logic          winc;
    logic [AW:0]   rq_ptr;
    logic          wclk_en;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wlevel;
    logic          woverflow;

    modport master (
        output winc, rq_ptr,
        input  wclk_en, waddr, wptr, wfull, walmost_full, wlevel, woverflow
    );

    modport slave (
        input  winc, rq_ptr,
        output wclk_en, waddr, wptr, wfull, walmost_full, wlevel, woverflow
    );

endinterface

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer entering the local clock domain.
// Shared by the write-side and read-side pointer blocks.
module fifo_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             WCLK,
    input  logic             WRST,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1;

    always_ff @(posedge WCLK or negedge WRST) begin
        if (!WRST) begin
            stage1 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer of an async FIFO: binary/Gray write pointer, registered full,
// almost-full and occupancy flags, and a sticky overflow flag.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter  int DEPTH    = DEFAULT_DEPTH,
    parameter  int AF_LEVEL = DEPTH - 2,
    localparam int AW       = ptr_addr_width(DEPTH),
    localparam int PW       = AW + 1
) (
    input  logic          WCLK,
    input  logic          WRST,
    input  logic          winc,
    input  logic [AW:0]   rq_ptr,
    output logic          wclk_en,
    output logic [AW-1:0] waddr,
    output logic [AW:0]   wptr,
    output logic          wfull,
    output logic          walmost_full,
    output logic [AW:0]   wlevel,
    output logic          woverflow
);

    logic [AW:0] rq2;
    logic [AW:0] wbin;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] rbin_sync;
    logic [AW:0] level_next;
    logic        full_next;
    logic        af_next;

    // The read pointer is only ever seen through the synchronizer.
    fifo_sync_2ff #(.WIDTH(PW)) u_rq_sync (
        .WCLK (WCLK),
        .WRST (WRST),
        .d    (rq_ptr),
        .q    (rq2)
    );

    assign wclk_en = winc & ~wfull;
    assign waddr   = wbin[AW-1:0];

    always_comb begin
        wbin_next  = wbin + {{AW{1'b0}}, wclk_en};
        wgray_next = PW'(bin2gray(gray_word_t'(wbin_next)));
        rbin_sync  = PW'(gray2bin(gray_word_t'(rq2)));
        // Full: same address, opposite wrap parity -> Gray top two bits inverted.
        full_next  = (wgray_next == {~rq2[AW:AW-1], rq2[AW-2:0]});
        level_next = wbin_next - rbin_sync;
        af_next    = full_next | (int'(level_next) >= AF_LEVEL);
    end

    always_ff @(posedge WCLK or negedge WRST) begin
        if (!WRST) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= full_next;
            walmost_full <= af_next;
            wlevel       <= level_next;
            woverflow    <= woverflow | (winc & wfull);
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full: fill table, release, wrap, almost-full,
// mid-operation reset and randomized traffic against a count-based occupancy model.
module tb_fifo_wptr_full;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AF    = 14;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    fifo_wptr_full_if #(.AW(AW)) bus ();

    fifo_wptr_full #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .WCLK         (clk),
        .WRST         (rst_n),
        .winc         (bus.winc),
        .rq_ptr       (bus.rq_ptr),
        .wclk_en      (bus.wclk_en),
        .waddr        (bus.waddr),
        .wptr         (bus.wptr),
        .wfull        (bus.wfull),
        .walmost_full (bus.walmost_full),
        .wlevel       (bus.wlevel),
        .woverflow    (bus.woverflow)
    );

    int checks   = 0;
    int failures = 0;

    // Model: counts of words written and read; the DUT sees the read count two edges late.
    int   m_wr, m_rd_cur, m_d1, m_d2, m_level;
    logic m_full, m_af, m_ovf;
    logic [AW:0] prev_wptr;

    typedef struct {
        logic winc;
        int   rd;
        int   exp_en;
        int   exp_waddr_pre;
        int   exp_waddr;
        int   exp_level;
        int   exp_full;
        int   exp_af;
        int   exp_ovf;
    } vec_t;

    vec_t fill_tab[17];

    function automatic logic [AW:0] to_gray(input int n);
        logic [AW:0] b;
        b = (AW+1)'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd_cur = 0; m_d1 = 0; m_d2 = 0; m_level = 0;
        m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
        prev_wptr = '0;
    endtask

    task automatic model_edge(input logic w);
        int old_d2;
        old_d2 = m_d2;
        if (w && m_full) m_ovf = 1'b1;
        if (w && !m_full) m_wr++;
        m_level = m_wr - old_d2;
        m_full  = (m_level == DEPTH);
        m_af    = (m_level >= AF);
        m_d2    = m_d1;
        m_d1    = m_rd_cur;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".waddr"}, int'(bus.waddr), m_wr % DEPTH);
        chk({tag, ".wptr"}, int'(bus.wptr), int'(to_gray(m_wr)));
        chk({tag, ".wfull"}, int'(bus.wfull), int'(m_full));
        chk({tag, ".walmost_full"}, int'(bus.walmost_full), int'(m_af));
        chk({tag, ".wlevel"}, int'(bus.wlevel), m_level);
        chk({tag, ".woverflow"}, int'(bus.woverflow), int'(m_ovf));
        chk({tag, ".gray_step"}, ($countones(bus.wptr ^ prev_wptr) <= 1) ? 1 : 0, 1);
        prev_wptr = bus.wptr;
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic cycle(input logic w, input int rd);
        bus.winc   = w;
        m_rd_cur   = rd;
        bus.rq_ptr = to_gray(rd);
        #1;
        chk("wclk_en", int'(bus.wclk_en), (w && !m_full) ? 1 : 0);
        @(posedge clk);
        model_edge(w);
        #1;
        check_regs("cyc");
    endtask

    task automatic do_reset();
        bus.winc   = 1'b1;
        bus.rq_ptr = '0;
        rst_n      = 1'b0;
        #1;
        chk("rst.waddr", int'(bus.waddr), 0);
        chk("rst.wptr", int'(bus.wptr), 0);
        chk("rst.wfull", int'(bus.wfull), 0);
        chk("rst.walmost_full", int'(bus.walmost_full), 0);
        chk("rst.wlevel", int'(bus.wlevel), 0);
        chk("rst.woverflow", int'(bus.woverflow), 0);
        chk("rst.wclk_en", int'(bus.wclk_en), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int hist[$];
        int rd;
        int rdpct;
        int wraps;
        int wr_before;
        logic [AW:0] wp_before;

        bus.winc   = 1'b0;
        bus.rq_ptr = '0;
        model_reset();

        for (int i = 0; i < 17; i++) begin
            fill_tab[i].winc          = 1'b1;
            fill_tab[i].rd            = 0;
            fill_tab[i].exp_en        = (i < 16) ? 1 : 0;
            fill_tab[i].exp_waddr_pre = (i < 16) ? i : 0;
            fill_tab[i].exp_waddr     = (i < 15) ? i + 1 : 0;
            fill_tab[i].exp_level     = (i < 16) ? i + 1 : 16;
            fill_tab[i].exp_full      = (i >= 15) ? 1 : 0;
            fill_tab[i].exp_af        = (i >= 13) ? 1 : 0;
            fill_tab[i].exp_ovf       = (i == 16) ? 1 : 0;
        end

        #1;
        do_reset();

        // Fill to full and one write past it.
        for (int i = 0; i < 17; i++) begin
            bus.winc   = fill_tab[i].winc;
            m_rd_cur   = fill_tab[i].rd;
            bus.rq_ptr = to_gray(fill_tab[i].rd);
            #1;
            chk("fill.wclk_en", int'(bus.wclk_en), fill_tab[i].exp_en);
            chk("fill.waddr_pre", int'(bus.waddr), fill_tab[i].exp_waddr_pre);
            @(posedge clk);
            model_edge(fill_tab[i].winc);
            #1;
            chk("fill.waddr", int'(bus.waddr), fill_tab[i].exp_waddr);
            chk("fill.wlevel", int'(bus.wlevel), fill_tab[i].exp_level);
            chk("fill.wfull", int'(bus.wfull), fill_tab[i].exp_full);
            chk("fill.walmost_full", int'(bus.walmost_full), fill_tab[i].exp_af);
            chk("fill.woverflow", int'(bus.woverflow), fill_tab[i].exp_ovf);
            check_regs("fill");
        end

        // Release: one read seen, full drops on the third edge.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1);
            chk("release.wfull", int'(bus.wfull), (k < 2) ? 1 : 0);
        end
        chk("release.wlevel", int'(bus.wlevel), 15);
        chk("release.walmost_full", int'(bus.walmost_full), 1);
        chk("release.woverflow", int'(bus.woverflow), 1);

        // Almost-full threshold.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, 0);
            if (i == 12) chk("af.before", int'(bus.walmost_full), 0);
        end
        chk("af.at14", int'(bus.walmost_full), 1);
        chk("af.wfull", int'(bus.wfull), 0);

        // Wrap: reader follows the write pointer three cycles behind.
        do_reset();
        wraps = 0;
        for (int i = 0; i < 40; i++) begin
            hist.push_back(m_wr);
            rd = (hist.size() > 3) ? hist[hist.size() - 4] : 0;
            wp_before = bus.wptr;
            wr_before = m_wr;
            cycle(1'b1, rd);
            chk("wrap.wfull", int'(bus.wfull), 0);
            if (wr_before == 31 && m_wr == 32) begin
                wraps++;
                chk("wrap.from", int'(wp_before), 16);
                chk("wrap.to", int'(bus.wptr), 0);
            end
        end
        chk("wrap.seen", wraps, 1);

        // Reset in the middle of traffic.
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, 0);
        do_reset();
        chk("midrst.waddr_pre", int'(bus.waddr), 0);
        cycle(1'b1, 0);
        chk("midrst.waddr", int'(bus.waddr), 1);
        chk("midrst.woverflow", int'(bus.woverflow), 0);

        // Randomized traffic with phases of slow and fast readers.
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            rdpct = (ph == 0) ? 20 : (ph == 1) ? 80 : (ph == 2) ? 50 : 10;
            for (int i = 0; i < 100; i++) begin
                rd = m_rd_cur;
                if (rd < m_wr && $urandom_range(0, 99) < rdpct) rd = rd + 1;
                cycle(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, rd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
